// File: rtl/uart_rx_deframer.sv
// uart_rx_deframer: oversampling UART receiver that recovers 8N1 frames onto a valid/ready byte interface.
//   clk, reset        : system clock, synchronous active-high reset
//   ena               : clock enable; freezes FSM, counters and outputs (synchronizer keeps running)
//   rx_signal         : asynchronous serial line, idle high
//   rx_data/rx_valid  : received byte, held stable while rx_valid is high
//   rx_ready          : consumer accepts the byte
//   frame_error       : 1-cycle pulse, stop bit sampled low
//   overrun           : 1-cycle pulse, completed byte dropped because the output register was full
//   parity_error      : 1-cycle pulse on even-parity mismatch; constant 0 unless UART_RX_PARITY_EN is defined
// Optional feature macro: UART_RX_PARITY_EN adds an even-parity bit between data and stop.
module uart_rx_deframer #(
  parameter int DATA_WIDTH = 8,
  parameter int BAUD_RATE  = 115_200,
  parameter int CLK_FREQ   = 50_000_000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  ena,
  input  logic                  rx_signal,
  output logic [DATA_WIDTH-1:0] rx_data,
  output logic                  rx_valid,
  input  logic                  rx_ready,
  output logic                  frame_error,
  output logic                  overrun,
  output logic                  parity_error
);
  localparam int CLKS_PER_BIT = CLK_FREQ / BAUD_RATE;
  localparam int CW = $clog2(CLKS_PER_BIT + 1);
  localparam int IW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CW-1:0] CNT_HALF = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, BREAK} state_t;

`ifdef UART_RX_PARITY_EN
  localparam state_t AFTER_DATA = PARITY;
`else
  localparam state_t AFTER_DATA = STOP;
`endif

  state_t                state_q;
  logic [1:0]            sync_q;
  logic [CW-1:0]         cnt_q;
  logic [IW-1:0]         idx_q;
  logic [DATA_WIDTH-1:0] shift_q;
  logic [DATA_WIDTH-1:0] data_q;
  logic                  valid_q;
  logic                  ferr_q;
  logic                  ovr_q;
  logic                  perr_q;
  logic                  bad_q;
  logic                  rxs;
  logic                  cnt_done;

  assign rxs          = sync_q[1];
  assign cnt_done     = cnt_q == CNT_LAST;
  assign rx_data      = data_q;
  assign rx_valid     = valid_q;
  assign frame_error  = ferr_q;
  assign overrun      = ovr_q;
  assign parity_error = perr_q;

  always_ff @(posedge clk) begin
    if (reset) sync_q <= 2'b11;
    else sync_q <= {sync_q[0], rx_signal};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      ovr_q   <= 1'b0;
      perr_q  <= 1'b0;
      bad_q   <= 1'b0;
    end else if (ena) begin
      ferr_q <= 1'b0;
      ovr_q  <= 1'b0;
      perr_q <= 1'b0;
      // a delivery later in this block overrides this clear
      if (valid_q && rx_ready) valid_q <= 1'b0;
      case (state_q)
        IDLE: if (!rxs) begin
          state_q <= START;
          cnt_q   <= '0;
        end
        START: if (cnt_q == CNT_HALF) begin
          cnt_q   <= '0;
          idx_q   <= '0;
          state_q <= rxs ? IDLE : DATA;
        end else cnt_q <= cnt_q + 1'b1;
        DATA: if (cnt_done) begin
          cnt_q          <= '0;
          shift_q[idx_q] <= rxs;
          idx_q          <= idx_q + 1'b1;
          state_q        <= (idx_q == IDX_LAST) ? AFTER_DATA : DATA;
        end else cnt_q <= cnt_q + 1'b1;
`ifdef UART_RX_PARITY_EN
        PARITY: if (cnt_done) begin
          cnt_q   <= '0;
          bad_q   <= ^{shift_q, rxs};
          perr_q  <= ^{shift_q, rxs};
          state_q <= STOP;
        end else cnt_q <= cnt_q + 1'b1;
`endif
        STOP: if (cnt_done) begin
          cnt_q <= '0;
          if (!rxs) begin
            ferr_q  <= 1'b1;
            state_q <= BREAK;
          end else begin
            state_q <= IDLE;
            if (!bad_q) begin
              // accept when empty or when the held byte is being consumed this edge
              if (!valid_q || rx_ready) begin
                data_q  <= shift_q;
                valid_q <= 1'b1;
              end else ovr_q <= 1'b1;
            end
          end
        end else cnt_q <= cnt_q + 1'b1;
        BREAK: if (rxs) state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_uart_rx_deframer.sv
// tb_uart_rx_deframer: randomized frame-level bench for uart_rx_deframer against a cycle-scheduled reference model.
module tb_uart_rx_deframer;
  localparam int DW  = 8;
  localparam int CPB = 10;
`ifdef UART_RX_PARITY_EN
  localparam int PB = 1;
`else
  localparam int PB = 0;
`endif

  typedef struct packed {
    logic       rx;
    logic       dlv;
    logic       fe;
    logic       pe;
    logic [7:0] d;
  } ev_t;

  logic          clk = 1'b0;
  logic          reset;
  logic          ena;
  logic          rx_signal;
  logic          rx_ready;
  logic [DW-1:0] rx_data;
  logic          rx_valid;
  logic          frame_error;
  logic          overrun;
  logic          parity_error;

  int   total = 0;
  int   bad = 0;
  int   rdy_mode;
  ev_t  line_q[$];
  logic mv, mfe, mov, mpe;
  logic [7:0] md;

  uart_rx_deframer #(
    .DATA_WIDTH(DW),
    .BAUD_RATE(100_000),
    .CLK_FREQ(1_000_000)
  ) dut (
    .clk(clk),
    .reset(reset),
    .ena(ena),
    .rx_signal(rx_signal),
    .rx_data(rx_data),
    .rx_valid(rx_valid),
    .rx_ready(rx_ready),
    .frame_error(frame_error),
    .overrun(overrun),
    .parity_error(parity_error)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // One line cycle: check outputs of the last edge, drive the next inputs, advance the model to the next edge.
  task automatic step(input logic rst, input logic en);
    ev_t  e;
    logic r;
    @(negedge clk);
    check("rx_valid", 32'(rx_valid), 32'(mv));
    check("rx_data", 32'(rx_data), 32'(md));
    check("frame_error", 32'(frame_error), 32'(mfe));
    check("overrun", 32'(overrun), 32'(mov));
    check("parity_error", 32'(parity_error), 32'(mpe));
    e = '0;
    e.rx = 1'b1;
    if (line_q.size() > 0) e = line_q.pop_front();
    r = (rdy_mode == 1) ? 1'b1 : (rdy_mode == 2) ? 1'b0 : (rdy_mode == 3) ? e.dlv : 1'($urandom_range(0, 1));
    reset = rst;
    ena = en;
    rx_signal = e.rx;
    rx_ready = r;
    if (rst) begin
      mv = 1'b0; md = '0; mfe = 1'b0; mov = 1'b0; mpe = 1'b0;
      for (int i = 0; i < line_q.size(); i++) begin
        e = line_q[i];
        e.dlv = 1'b0; e.fe = 1'b0; e.pe = 1'b0;
        line_q[i] = e;
      end
    end else if (en) begin
      mfe = e.fe;
      mpe = e.pe;
      mov = 1'b0;
      if (e.dlv) begin
        if (!mv || r) begin
          md = e.d;
          mv = 1'b1;
        end else mov = 1'b1;
      end else if (mv && r) mv = 1'b0;
    end
  endtask

  task automatic push_lvl(input logic b, input int n);
    ev_t e;
    e = '0;
    e.rx = b;
    repeat (n) line_q.push_back(e);
  endtask

  // Frame whose start bit is first driven at queue position p0. Its stop (or parity) sample
  // happens on the edge closing cycle p0+97 (+CPB per parity bit): 2 sync + 1 detect + 5 half-bit + 90.
  task automatic send_frame(input logic [7:0] d, input logic stop_ok, input logic par_bad);
    int   p0;
    ev_t  e;
    logic pb;
    pb = (PB == 1) && par_bad;
    p0 = line_q.size();
    push_lvl(1'b0, CPB);
    for (int i = 0; i < 8; i++) push_lvl(d[i], CPB);
    if (PB == 1) push_lvl((^d) ^ pb, CPB);
    push_lvl(stop_ok, CPB);
    if (pb) begin
      e = line_q[p0 + 97];
      e.pe = 1'b1;
      line_q[p0 + 97] = e;
    end
    e = line_q[p0 + 97 + CPB * PB];
    e.fe = !stop_ok;
    e.dlv = stop_ok && !pb;
    e.d = d;
    line_q[p0 + 97 + CPB * PB] = e;
  endtask

  task automatic drain();
    while (line_q.size() > 0) step(1'b0, 1'b1);
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, 1'b1);
  endtask

  initial begin
    reset = 1'b1; ena = 1'b1; rx_signal = 1'b1; rx_ready = 1'b0; rdy_mode = 1;
    mv = 1'b0; md = '0; mfe = 1'b0; mov = 1'b0; mpe = 1'b0;
    repeat (2) @(negedge clk);
    idle(3);
    send_frame(8'hA5, 1'b1, 1'b0);
    drain();
    idle(5);
    push_lvl(1'b0, 3);
    push_lvl(1'b1, 10);
    send_frame(8'h3C, 1'b1, 1'b0);
    drain();
    send_frame(8'h55, 1'b0, 1'b0);
    push_lvl(1'b0, 50);
    push_lvl(1'b1, 2);
    send_frame(8'h0F, 1'b1, 1'b0);
    drain();
    idle(5);
    rdy_mode = 2;
    send_frame(8'h11, 1'b1, 1'b0);
    send_frame(8'h22, 1'b1, 1'b0);
    drain();
    idle(5);
    rdy_mode = 1;
    step(1'b0, 1'b1);
    rdy_mode = 2;
    idle(5);
    rdy_mode = 3;
    send_frame(8'h11, 1'b1, 1'b0);
    send_frame(8'h22, 1'b1, 1'b0);
    drain();
    idle(3);
    rdy_mode = 1;
    repeat (5) step(1'b0, 1'b0);
    idle(3);
    rdy_mode = 2;
    send_frame(8'h5A, 1'b1, 1'b0);
    drain();
    send_frame(8'hFF, 1'b1, 1'b0);
    repeat (40) step(1'b0, 1'b1);
    step(1'b1, 1'b1);
    drain();
    idle(5);
    rdy_mode = 1;
    send_frame(8'h81, 1'b1, 1'b0);
    drain();
    send_frame(8'h81, 1'b1, 1'b1);
    drain();
    idle(5);
    for (int k = 0; k < 150; k++) begin
      int   kind;
      logic so;
      kind = $urandom_range(0, 9);
      so = kind != 1;
      if ($urandom_range(0, 7) == 0) rdy_mode = $urandom_range(0, 3);
      if (kind == 0) begin
        push_lvl(1'b0, $urandom_range(1, 4));
        push_lvl(1'b1, 8 + $urandom_range(0, 5));
      end else begin
        send_frame(8'($urandom), so, $urandom_range(0, 3) == 0);
        if (!so) begin
          push_lvl(1'b0, $urandom_range(0, 30));
          push_lvl(1'b1, 2 + $urandom_range(0, 5));
        end else push_lvl(1'b1, $urandom_range(0, 12));
      end
      while (line_q.size() > 20) step(1'b0, 1'b1);
    end
    drain();
    idle(20);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/uart_rx_deframer.md
Name: uart_rx_deframer

Overview:
- Receive stage of the board-link UART: oversamples the asynchronous serial rx line, recovers 8N1 frames and presents each byte on a valid/ready interface.
- Sits between the rx pad input and any consumer of rx_data, such as the tx loopback path or a command parser.
- Flags framing errors and overruns as single-cycle pulses.

Parameters:
- DATA_WIDTH, 8: data bits per frame, sent LSB first.
- BAUD_RATE, 115_200: line bit rate.
- CLK_FREQ, 50_000_000: clk frequency in Hz.
- CLKS_PER_BIT (localparam), CLK_FREQ/BAUD_RATE, integer division: 434 at the defaults.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- ena  in  1  clock enable. When 0, all state, counters and outputs hold, except the synchronizer.
- rx_signal  in  1  asynchronous serial line; idle high.
- rx_data  out  DATA_WIDTH  received byte; stable while rx_valid=1.
- rx_valid  out  1  byte available.
- rx_ready  in  1  consumer accepts the byte.
- frame_error  out  1  1-cycle pulse: stop bit sampled low.
- overrun  out  1  1-cycle pulse: a completed byte was dropped because the output register was still full.

Behaviour:
- Reset (one clk edge with reset=1):
  - state=IDLE, counters=0.
  - Both synchronizer flops = 1.
  - rx_data=0, rx_valid=0, frame_error=0, overrun=0.
- Synchronizer: 2-flop, always clocked, independent of ena. The FSM uses only the synchronized value rxs.
- Bit counter cnt runs 0..CLKS_PER_BIT-1. Bit index idx runs 0..DATA_WIDTH-1.
- IDLE: when rxs=0, go to START with cnt=0.
- START: at cnt=CLKS_PER_BIT/2-1, sample rxs.
  - If rxs=1, it was a glitch: return to IDLE and output nothing.
  - If rxs=0, go to DATA with cnt=0, idx=0.
- DATA: at cnt=CLKS_PER_BIT-1, shift rxs into the shift register at bit idx (LSB first) and reset cnt.
  - After idx=DATA_WIDTH-1, go to STOP.
- STOP: at cnt=CLKS_PER_BIT-1, sample rxs.
  - rxs=1: deliver the byte and go to IDLE.
  - rxs=0: pulse frame_error for one cycle, discard the byte, go to BREAK.
- BREAK: wait until rxs=1, then go to IDLE. A held-low line produces exactly one frame_error.
- Deliver, on the cycle after the stop sample:
  - If rx_valid=0, or (rx_valid & rx_ready) is true on the same cycle: load rx_data, set rx_valid=1. No overrun.
  - Otherwise: keep the old rx_data and rx_valid, and pulse overrun for one cycle.
- Handshake:
  - rx_valid clears on the cycle after a clk edge where rx_valid & rx_ready, unless a delivery occurs on that same edge.
  - rx_ready while rx_valid=0 is ignored.
- Latency: rx_valid rises at the first-falling-edge cycle + 2 + CLKS_PER_BIT/2 + (DATA_WIDTH+1)*CLKS_PER_BIT + 1 cycles.
- The FSM starts looking for the next start bit directly from IDLE, so back-to-back frames with a single stop bit are received without loss.
- reset asserted mid-frame: the partial byte is discarded and all outputs return to their reset values on the next edge.
- ena=0 mid-frame: the FSM freezes. Frame alignment is the integrator's responsibility.

Optional Feature:
- Macro: UART_RX_PARITY_EN.
- When defined:
  - A PARITY state sits between DATA and STOP and samples 1 bit at cnt=CLKS_PER_BIT-1.
  - Even parity over the data bits plus the parity bit must be 0.
  - A mismatch pulses output parity_error for 1 cycle and discards the byte. The FSM still proceeds through STOP, and a low stop bit additionally pulses frame_error.
  - Latency grows by CLKS_PER_BIT.
- When not defined:
  - 8N1 framing only.
  - The parity_error port exists and is tied to 0.

Test Plan:
- CLK_FREQ=1_000_000, BAUD_RATE=100_000 (CLKS_PER_BIT=10), rx_ready=1, send 0xA5 8N1 → rx_valid high 1 cycle with rx_data=0xA5, at falling edge + 2+5+90+1 = 98 cycles; frame_error=0, overrun=0.
- rx_signal low pulse of 3 cycles, then high → no rx_valid, FSM back in IDLE; a following 0x3C frame is received correctly.
- Frame 0x55 with stop bit low, then line held low 50 cycles → exactly one frame_error pulse, no rx_valid; next frame 0x0F is received.
- rx_ready=0, send 0x11 then 0x22 back-to-back → rx_data=0x11 held with rx_valid=1, one overrun pulse at the second delivery. Then rx_ready=1 for 1 cycle → rx_valid=0.
- rx_ready is asserted on the exact cycle of the second delivery (0x22 after 0x11) → rx_data=0x22, rx_valid stays 1, no overrun.
- Assert reset mid-DATA of frame 0xFF → outputs return to zero, no delivery; the next 0x81 frame is received correctly. With UART_RX_PARITY_EN, 0x81 with parity bit 1 → parity_error pulse, no rx_valid.
